// File: rtl/lcd_instr_writer.sv
// HD44780 instruction display writer: power-up init, then renders opcode/register/value
// as two 16-character lines on request.
module lcd_instr_writer #(
  parameter int POWERUP_CYC = 1000000,
  parameter int CMD_CYC     = 2500,
  parameter int CLEAR_CYC   = 100000,
  parameter int EN_HIGH_CYC = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [3:0]  reg_idx,
  input  logic [15:0] value,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon
);

  // state     | meaning
  // INIT_WAIT | power-up delay after reset release
  // INIT_CMD  | select first init command
  // IDLE      | ready for a request (only non-busy state)
  // CONVERT   | binary to decimal by repeated subtraction
  // SETUP     | data/rs valid, en low for one cycle
  // EN_HI     | en high for EN_HIGH_CYC cycles
  // EN_WAIT   | en low until the byte period has elapsed
  typedef enum logic [2:0] {
    INIT_WAIT, INIT_CMD, IDLE, CONVERT, SETUP, EN_HI, EN_WAIT
  } state_t;

  localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYC - 1);
  localparam logic [31:0] EN_LAST  = 32'(EN_HIGH_CYC - 1);
  localparam logic [31:0] CMD_WAIT = 32'(CMD_CYC - EN_HIGH_CYC - 1);
  localparam logic [31:0] CLR_WAIT = 32'(CLEAR_CYC - EN_HIGH_CYC - 1);

  state_t           r_state, w_state_nx;
  logic [31:0]      r_tmr, w_tmr_nx;
  logic [5:0]       r_idx, w_idx_nx;
  logic             r_init, w_init_nx;
  logic [2:0]       r_opcode;
  logic [3:0]       r_reg;
  logic             r_neg;
  logic [15:0]      r_mag;
  logic [2:0]       r_pos;
  logic [4:0][3:0]  r_dig;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_rs;
  logic             r_lcd_en;

  logic             w_conv_done;
  logic [15:0]      w_pow;
  logic [7:0]       w_byte;
  logic             w_rs;
  logic [31:0]      w_mnem;
  logic [3:0]       w_p1, w_p2;
  logic [3:0]       w_reg_d1, w_reg_d0;
  logic [7:0]       w_l1_char, w_l2_char;
  logic             w_is_clear;

  assign busy     = (r_state != IDLE);
  assign lcd_data = r_lcd_data;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_en   = r_lcd_en;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

  assign w_conv_done = (r_pos == 3'd3) && (r_mag < 16'd10);
  assign w_is_clear  = (r_lcd_data == 8'h01) && !r_lcd_rs;

  always_comb begin
    w_pow = 16'd10;
    case (r_pos)
      3'd0:    w_pow = 16'd10000;
      3'd1:    w_pow = 16'd1000;
      3'd2:    w_pow = 16'd100;
      default: w_pow = 16'd10;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_idx_nx   = r_idx;
    w_init_nx  = r_init;
    case (r_state)
      INIT_WAIT: begin
        if (r_tmr == PWR_LAST) begin
          w_state_nx = INIT_CMD;
          w_tmr_nx   = '0;
        end else begin
          w_tmr_nx = r_tmr + 32'd1;
        end
      end
      INIT_CMD: begin
        w_state_nx = SETUP;
        w_idx_nx   = '0;
        w_init_nx  = 1'b1;
      end
      IDLE: begin
        if (start) w_state_nx = CONVERT;
      end
      CONVERT: begin
        if (w_conv_done) begin
          w_state_nx = SETUP;
          w_idx_nx   = '0;
        end
      end
      SETUP: begin
        w_state_nx = EN_HI;
        w_tmr_nx   = EN_LAST;
      end
      EN_HI: begin
        if (r_tmr == '0) begin
          w_state_nx = EN_WAIT;
          w_tmr_nx   = w_is_clear ? CLR_WAIT : CMD_WAIT;
        end else begin
          w_tmr_nx = r_tmr - 32'd1;
        end
      end
      EN_WAIT: begin
        if (r_tmr != '0) begin
          w_tmr_nx = r_tmr - 32'd1;
        end else if ((r_init && r_idx == 6'd3) || (!r_init && r_idx == 6'd33)) begin
          w_state_nx = IDLE;
          w_init_nx  = 1'b0;
          w_idx_nx   = '0;
        end else begin
          w_state_nx = SETUP;
          w_idx_nx   = r_idx + 6'd1;
        end
      end
      default: w_state_nx = INIT_WAIT;
    endcase
  end

  always_comb begin
    w_mnem = "LOAD";
    case (r_opcode)
      3'd0: w_mnem = "LOAD";
      3'd1: w_mnem = "ADD ";
      3'd2: w_mnem = "ADDI";
      3'd3: w_mnem = "SUB ";
      3'd4: w_mnem = "SUBI";
      3'd5: w_mnem = "MUL ";
      3'd6: w_mnem = "CLR ";
      3'd7: w_mnem = "DISP";
      default: w_mnem = "LOAD";
    endcase
  end

  always_comb begin
    w_reg_d1 = 4'd0;
    w_reg_d0 = r_reg;
    if (r_reg >= 4'd10) begin
      w_reg_d1 = 4'd1;
      w_reg_d0 = r_reg - 4'd10;
    end
  end

  // Positions wrap mod 16: byte 1..16 is line-1 column 0..15, byte 18..33 is line-2 column 0..15.
  assign w_p1 = w_idx_nx[3:0] - 4'd1;
  assign w_p2 = w_idx_nx[3:0] - 4'd2;

  always_comb begin
    w_l1_char = 8'h20;
    case (w_p1)
      4'd0:    w_l1_char = w_mnem[31:24];
      4'd1:    w_l1_char = w_mnem[23:16];
      4'd2:    w_l1_char = w_mnem[15:8];
      4'd3:    w_l1_char = w_mnem[7:0];
      4'd5:    w_l1_char = 8'h52;
      4'd6:    w_l1_char = {4'h3, w_reg_d1};
      4'd7:    w_l1_char = {4'h3, w_reg_d0};
      default: w_l1_char = 8'h20;
    endcase
  end

  always_comb begin
    w_l2_char = 8'h20;
    case (w_p2)
      4'd0:    w_l2_char = r_neg ? 8'h2D : 8'h2B;
      4'd1:    w_l2_char = {4'h3, r_dig[0]};
      4'd2:    w_l2_char = {4'h3, r_dig[1]};
      4'd3:    w_l2_char = {4'h3, r_dig[2]};
      4'd4:    w_l2_char = {4'h3, r_dig[3]};
      4'd5:    w_l2_char = {4'h3, r_dig[4]};
      default: w_l2_char = 8'h20;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    w_rs   = 1'b0;
    if (w_init_nx) begin
      case (w_idx_nx[1:0])
        2'd0:    w_byte = 8'h38;
        2'd1:    w_byte = 8'h0C;
        2'd2:    w_byte = 8'h06;
        default: w_byte = 8'h01;
      endcase
    end else if (w_idx_nx == 6'd0) begin
      w_byte = 8'h80;
    end else if (w_idx_nx <= 6'd16) begin
      w_byte = w_l1_char;
      w_rs   = 1'b1;
    end else if (w_idx_nx == 6'd17) begin
      w_byte = 8'hC0;
    end else begin
      w_byte = w_l2_char;
      w_rs   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= INIT_WAIT;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_init     <= 1'b1;
      r_opcode   <= '0;
      r_reg      <= '0;
      r_neg      <= 1'b0;
      r_mag      <= '0;
      r_pos      <= '0;
      r_dig      <= '0;
      r_lcd_data <= '0;
      r_lcd_rs   <= 1'b0;
      r_lcd_en   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tmr    <= w_tmr_nx;
      r_idx    <= w_idx_nx;
      r_init   <= w_init_nx;
      r_lcd_en <= (w_state_nx == EN_HI);
      // Output byte is registered once on entry to SETUP and held for the whole write.
      if (w_state_nx == SETUP) begin
        r_lcd_data <= w_byte;
        r_lcd_rs   <= w_rs;
      end
      if (r_state == IDLE && start) begin
        r_opcode <= opcode;
        r_reg    <= reg_idx;
        r_neg    <= value[15];
        r_mag    <= value[15] ? (~value + 16'd1) : value;
        r_pos    <= '0;
        r_dig    <= '0;
      end
      if (r_state == CONVERT) begin
        if (w_conv_done) begin
          r_dig[4] <= r_mag[3:0];
        end else if (r_mag >= w_pow) begin
          r_mag        <= r_mag - w_pow;
          r_dig[r_pos] <= r_dig[r_pos] + 4'd1;
        end else begin
          r_pos <= r_pos + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/lcd_instr_writer.md
LCD_INSTR_WRITER -- requirements
Module: lcd_instr_writer

Interface
REQ-001 Parameter POWERUP_CYC, 1000000, idle cycles after reset release before first command (20 ms at 50 MHz).
REQ-002 Parameter CMD_CYC, 2500, cycles from EN rising edge to next byte for every byte except clear (50 us).
REQ-003 Parameter CLEAR_CYC, 100000, cycles from EN rising edge to next byte after command 0x01 (2 ms).
REQ-004 Parameter EN_HIGH_CYC, 25, cycles lcd_en is held high per byte.
REQ-005 clk  in  1  single system clock; all state on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to display a new instruction.
REQ-008 opcode  in  3  instruction code (000 LOAD … 111 DISPLAY).
REQ-009 reg_idx  in  4  register number 0–15.
REQ-010 value  in  16  two's-complement value to show.
REQ-011 busy  out  1  high whenever a request would not be accepted.
REQ-012 lcd_data  out  8  HD44780 data bus.
REQ-013 lcd_rs  out  1  0 = command, 1 = character.
REQ-014 lcd_rw  out  1  always 0 (write only).
REQ-015 lcd_en  out  1  enable strobe.
REQ-016 lcd_on  out  1  constant 1.
REQ-017 lcd_blon  out  1  constant 1.

Function
REQ-018 The FSM SHALL use the states INIT_WAIT, INIT_CMD, IDLE, CONVERT, SETUP, EN_HI and EN_WAIT.
REQ-019 After reset, the block SHALL wait POWERUP_CYC cycles, then write commands 0x38, 0x0C, 0x06, 0x01 in that order with rs=0, then enter IDLE.
REQ-020 busy SHALL be 0 only in IDLE.
REQ-021 A request SHALL be accepted when start=1 in a cycle with busy=0; at acceptance the block SHALL capture opcode, reg_idx and value.
REQ-022 busy SHALL be 1 from the cycle after acceptance.
REQ-023 start while busy=1, including during init, SHALL be ignored and not queued.
REQ-024 Byte write: SETUP drives lcd_data/lcd_rs for 1 cycle with en=0; EN_HI holds en=1 for EN_HIGH_CYC cycles; EN_WAIT holds en=0 until CMD_CYC (or CLEAR_CYC for 0x01) cycles have elapsed since en rose; data/rs stay stable throughout.
REQ-025 CONVERT SHALL produce the sign and 5 decimal digits sequentially by repeated subtraction of 10000, 1000, 100 and 10, finishing within 50 cycles.
REQ-026 The magnitude SHALL be the 16-bit negation when value[15]=1, so 0x8000 converts to 32768.
REQ-027 The register number SHALL be converted to 2 decimal digits.
REQ-028 Per request, the block SHALL write 34 bytes: command 0x80, 16 characters of line 1, command 0xC0, 16 characters of line 2, then return to IDLE.
REQ-029 Line 1 SHALL be mnemonic(4) + ' ' + 'R' + d1 + d0 + 8 spaces.
REQ-030 Mnemonics SHALL be: 000 "LOAD", 001 "ADD ", 010 "ADDI", 011 "SUB ", 100 "SUBI", 101 "MUL ", 110 "CLR ", 111 "DISP".
REQ-031 Line 2 SHALL be sign ('+' if value[15]=0, else '-') + 5 digits with leading zeros + 10 spaces.
REQ-032 Characters SHALL be ASCII: digits 0x30–0x39, space 0x20, '+' 0x2B, '-' 0x2D, 'R' 0x52.
REQ-033 Captured fields SHALL remain constant until the sequence completes, regardless of input changes.

Reset
REQ-034 reset_n=0 SHALL immediately force: lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=1, lcd_on=1, lcd_blon=1, state INIT_WAIT, and all counters and captured fields cleared.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence with no completion of the current byte; after release the full init sequence (REQ-019) SHALL repeat.

Verification
Bench parameters: POWERUP_CYC=100, CMD_CYC=20, CLEAR_CYC=50, EN_HIGH_CYC=4.
REQ-036 Reset release -> no en pulse for 100 cycles, then bytes 0x38, 0x0C, 0x06, 0x01 with rs=0, en high 4 cycles each, 50-cycle gap after 0x01, then busy=0.
REQ-037 start, opcode=000, reg_idx=5, value=0x0007 -> 0x80, "LOAD R05        ", 0xC0, "+00007          ", then busy=0.
REQ-038 opcode=011, reg_idx=15, value=0xFFF6 -> line 1 "SUB  R15        ", line 2 "-00010          ".
REQ-039 opcode=111, value=0x8000 -> line 2 "-32768"; then value=0x7FFF -> line 2 "+32767".
REQ-040 Second start pulse mid-sequence with different fields -> ignored; exactly 34 bytes are written, all from the first request.
REQ-041 reset_n low during byte 10 of a sequence -> outputs reach reset values the same cycle, with no further en pulses until the init sequence restarts after release.
